logu_schraudolph_pipe: RTL and testbench

LOGU_SCHRAUDOLPH_PIPE -- requirements
Module: logu_schraudolph_pipe

---
 rtl/logu_schraudolph_pipe.sv | 192 +++++++++++++++++++
 tb/tb_logu_schraudolph_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logu_schraudolph_pipe.sv
// Three-stage elastic pipeline approximating ln(x) with the inverse Schraudolph trick:
// reinterpret the FP bit field as log2(x) in fixed point, scale by ln(2), repack as FP.
module logu_schraudolph_pipe #(
    parameter int FPFORMAT         = 4,  // fpnew_pkg::fp_format_e: 0 FP32, 1 FP64, 2 FP16, 3 FP8, 4 FP16ALT
    parameter int A_FRACTION       = 14,
    parameter bit ENABLE_ROUNDING  = 1'b1,
    parameter int TAG_WIDTH        = 4,
    localparam int EXPONENT_BITS   = (FPFORMAT == 1) ? 11 : ((FPFORMAT == 2) || (FPFORMAT == 3)) ? 5 : 8,
    localparam int MANTISSA_BITS   = (FPFORMAT == 0) ? 23 : (FPFORMAT == 1) ? 52 :
                                     (FPFORMAT == 2) ? 10 : (FPFORMAT == 3) ? 2 : 7,
    localparam int WIDTH           = 1 + EXPONENT_BITS + MANTISSA_BITS,
    localparam int BIAS            = (2 ** (EXPONENT_BITS - 1)) - 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     op_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WIDTH-1:0]     res_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic                 busy_o
);

    localparam int SW         = EXPONENT_BITS + MANTISSA_BITS;
    localparam int PW         = SW + A_FRACTION;
    localparam int FRAC_SHIFT = MANTISSA_BITS + A_FRACTION;

    localparam logic [A_FRACTION-1:0] LN2_Q =
        A_FRACTION'($rtoi(0.6931471805599453 * (2.0 ** A_FRACTION) + 0.5));
    localparam logic [SW:0] BIAS_FIELD = (SW + 1)'(BIAS) << MANTISSA_BITS;

    localparam logic [WIDTH-1:0] QNAN    = {1'b0, {EXPONENT_BITS{1'b1}}, 1'b1, {(MANTISSA_BITS - 1){1'b0}}};
    localparam logic [WIDTH-1:0] NEG_INF = {1'b1, {EXPONENT_BITS{1'b1}}, {MANTISSA_BITS{1'b0}}};
    localparam logic [WIDTH-1:0] POS_INF = {1'b0, {EXPONENT_BITS{1'b1}}, {MANTISSA_BITS{1'b0}}};

    // Stage registers
    logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic                 s1_neg_q, s1_neg_d, s1_spec_q, s1_spec_d;
    logic [SW-1:0]        s1_mag_q, s1_mag_d;
    logic [WIDTH-1:0]     s1_sval_q, s1_sval_d;
    logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
    logic                 s2_neg_q, s2_neg_d, s2_spec_q, s2_spec_d;
    logic [PW-1:0]        s2_prod_q, s2_prod_d;
    logic [WIDTH-1:0]     s2_sval_q, s2_sval_d;
    logic [TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [TAG_WIDTH-1:0] tag3_q, tag3_d;

    // Stage-load enables: a stage takes new data when it is empty or its content moves on.
    logic en1, en2, en3;
    assign en3     = ~v3_q | ready_i;
    assign en2     = ~v2_q | en3;
    assign en1     = ~v1_q | en2;
    assign ready_o = en1 & ~clear_i;
    assign valid_o = v3_q;
    assign res_o   = res_q;
    assign tag_o   = tag3_q;
    assign busy_o  = v1_q | v2_q | v3_q;

    // S1 classification and S = field - (BIAS << MANTISSA_BITS)
    logic [EXPONENT_BITS-1:0] exp_f;
    logic [MANTISSA_BITS-1:0] man_f;
    logic signed [SW:0]       s_val;
    logic                     c_spec;
    logic [WIDTH-1:0]         c_sval;

    always_comb begin
        exp_f  = op_i[WIDTH-2 -: EXPONENT_BITS];
        man_f  = op_i[MANTISSA_BITS-1:0];
        s_val  = signed'({1'b0, op_i[WIDTH-2:0]}) - signed'(BIAS_FIELD);
        c_spec = 1'b1;
        c_sval = '0;
        // Negative subnormals count as negative nonzero operands and give NaN.
        if ((&exp_f) && (|man_f))        c_sval = QNAN;
        else if (~|exp_f && ~|man_f)     c_sval = NEG_INF;
        else if (op_i[WIDTH-1])          c_sval = QNAN;
        else if (~|exp_f)                c_sval = NEG_INF;
        else if (&exp_f)                 c_sval = POS_INF;
        else if (s_val == 0)             c_sval = '0;
        else                             c_spec = 1'b0;
    end

    // S3 normalization
    int                     lead;
    int                     lz;
    logic [PW-1:0]          norm;
    logic [MANTISSA_BITS:0] mant_g;
    logic [MANTISSA_BITS:0] mant_r;
    int                     exp_i;
    logic [WIDTH-1:0]       res_c;

    always_comb begin
        lead = 0;
        for (int i = 0; i < PW; i++) begin
            if (s2_prod_q[i]) lead = i;
        end
        lz     = PW - 1 - lead;
        norm   = s2_prod_q << (lz + 1);
        mant_g = (MANTISSA_BITS + 1)'(norm >> (PW - 1 - MANTISSA_BITS));
        mant_r = {1'b0, mant_g[MANTISSA_BITS:1]} + {{MANTISSA_BITS{1'b0}}, ENABLE_ROUNDING & mant_g[0]};
        // A rounding carry leaves the mantissa field at zero and bumps the exponent.
        exp_i  = BIAS + lead - FRAC_SHIFT + int'(mant_r[MANTISSA_BITS]);
        res_c  = s2_spec_q ? s2_sval_q
                           : {s2_neg_q, EXPONENT_BITS'(exp_i), mant_r[MANTISSA_BITS-1:0]};
    end

    always_comb begin
        v1_d      = v1_q;
        v2_d      = v2_q;
        v3_d      = v3_q;
        s1_neg_d  = s1_neg_q;
        s1_mag_d  = s1_mag_q;
        s1_spec_d = s1_spec_q;
        s1_sval_d = s1_sval_q;
        s1_tag_d  = s1_tag_q;
        s2_neg_d  = s2_neg_q;
        s2_prod_d = s2_prod_q;
        s2_spec_d = s2_spec_q;
        s2_sval_d = s2_sval_q;
        s2_tag_d  = s2_tag_q;
        res_d     = res_q;
        tag3_d    = tag3_q;
        if (clear_i) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
            v3_d = 1'b0;
        end else begin
            if (en1) v1_d = valid_i;
            if (en2) v2_d = v1_q;
            if (en3) v3_d = v2_q;
            if (en1 && valid_i) begin
                s1_neg_d  = s_val[SW];
                s1_mag_d  = s_val[SW] ? SW'(-s_val) : SW'(s_val);
                s1_spec_d = c_spec;
                s1_sval_d = c_sval;
                s1_tag_d  = tag_i;
            end
            if (en2 && v1_q) begin
                s2_neg_d  = s1_neg_q;
                s2_prod_d = PW'(s1_mag_q) * PW'(LN2_Q);
                s2_spec_d = s1_spec_q;
                s2_sval_d = s1_sval_q;
                s2_tag_d  = s1_tag_q;
            end
            if (en3 && v2_q) begin
                res_d  = res_c;
                tag3_d = s2_tag_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            s1_neg_q  <= 1'b0;
            s1_mag_q  <= '0;
            s1_spec_q <= 1'b0;
            s1_sval_q <= '0;
            s1_tag_q  <= '0;
            s2_neg_q  <= 1'b0;
            s2_prod_q <= '0;
            s2_spec_q <= 1'b0;
            s2_sval_q <= '0;
            s2_tag_q  <= '0;
            res_q     <= '0;
            tag3_q    <= '0;
        end else begin
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            v3_q      <= v3_d;
            s1_neg_q  <= s1_neg_d;
            s1_mag_q  <= s1_mag_d;
            s1_spec_q <= s1_spec_d;
            s1_sval_q <= s1_sval_d;
            s1_tag_q  <= s1_tag_d;
            s2_neg_q  <= s2_neg_d;
            s2_prod_q <= s2_prod_d;
            s2_spec_q <= s2_spec_d;
            s2_sval_q <= s2_sval_d;
            s2_tag_q  <= s2_tag_d;
            res_q     <= res_d;
            tag3_q    <= tag3_d;
        end
    end

endmodule

// File: tb/tb_logu_schraudolph_pipe.sv
// Bench for logu_schraudolph_pipe: a rounding and a truncating instance share one stimulus
// stream; each has its own expected queue fed from an arithmetic reference of ln(x).
module tb_logu_schraudolph_pipe;

    localparam int W  = 16;
    localparam int TW = 4;
    localparam int QW = W + TW;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          clear_i, valid_i, ready_i;
    logic [W-1:0]  op_i;
    logic [TW-1:0] tag_i;
    logic          ready_o_r, valid_o_r, busy_o_r, ready_o_t, valid_o_t, busy_o_t;
    logic [W-1:0]  res_o_r, res_o_t;
    logic [TW-1:0] tag_o_r, tag_o_t;

    logu_schraudolph_pipe #(.ENABLE_ROUNDING(1'b1)) dut_r (
        .clk_i(clk), .rst_i(rst), .clear_i(clear_i), .valid_i(valid_i), .ready_o(ready_o_r),
        .op_i(op_i), .tag_i(tag_i), .valid_o(valid_o_r), .ready_i(ready_i), .res_o(res_o_r),
        .tag_o(tag_o_r), .busy_o(busy_o_r));

    logu_schraudolph_pipe #(.ENABLE_ROUNDING(1'b0)) dut_t (
        .clk_i(clk), .rst_i(rst), .clear_i(clear_i), .valid_i(valid_i), .ready_o(ready_o_t),
        .op_i(op_i), .tag_i(tag_i), .valid_o(valid_o_t), .ready_i(ready_i), .res_o(res_o_t),
        .tag_o(tag_o_t), .busy_o(busy_o_t));

    int n_cmp = 0;
    int n_err = 0;
    logic [QW-1:0] exp_r_q[$];
    logic [QW-1:0] exp_t_q[$];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Reference: ln(x) for FP16ALT via plain integer arithmetic
    function automatic logic [15:0] ref_ln(input logic [15:0] x, input bit rnd);
        int     e, m, s, mag, p, ex, mant, guard;
        longint prod, frac;
        bit     neg;
        e = int'(x[14:7]);
        m = int'(x[6:0]);
        if (e == 255 && m != 0) return 16'h7FC0;
        if (e == 0 && m == 0)   return 16'hFF80;
        if (x[15])              return 16'h7FC0;
        if (e == 0)             return 16'hFF80;
        if (e == 255)           return 16'h7F80;
        s = e * 128 + m - 127 * 128;
        if (s == 0) return 16'h0000;
        neg  = (s < 0);
        mag  = neg ? -s : s;
        prod = longint'(mag) * 11357;
        p = 0;
        while ((prod >> (p + 1)) != 0) p++;
        frac  = prod - (longint'(1) << p);
        mant  = int'(frac >> (p - 7));
        guard = int'((frac >> (p - 8)) & 1);
        if (rnd) mant += guard;
        ex = 106 + p;
        if (mant == 128) begin
            mant = 0;
            ex++;
        end
        return {neg, ex[7:0], mant[6:0]};
    endfunction

    function automatic logic [15:0] rand_op();
        logic       sg;
        logic [7:0] e;
        logic [6:0] m;
        sg = ($urandom_range(0, 9) == 0);
        e  = 8'($urandom_range(1, 254));
        m  = 7'($urandom_range(0, 127));
        return {sg, e, m};
    endfunction

    // Scoreboard monitor: samples one time unit before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (rst || clear_i) begin
            exp_r_q.delete();
            exp_t_q.delete();
        end else begin
            if (valid_o_r && ready_i) begin
                check("sb_nonempty_r", 32'(exp_r_q.size() != 0), 32'd1);
                if (exp_r_q.size() != 0) check("sb_res_r", 32'({tag_o_r, res_o_r}), 32'(exp_r_q.pop_front()));
            end
            if (valid_o_t && ready_i) begin
                check("sb_nonempty_t", 32'(exp_t_q.size() != 0), 32'd1);
                if (exp_t_q.size() != 0) check("sb_res_t", 32'({tag_o_t, res_o_t}), 32'(exp_t_q.pop_front()));
            end
            if (valid_i && ready_o_r) exp_r_q.push_back({tag_i, ref_ln(op_i, 1'b1)});
            if (valid_i && ready_o_t) exp_t_q.push_back({tag_i, ref_ln(op_i, 1'b0)});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_one(input logic [15:0] op, input logic [3:0] tag, input logic [15:0] exp_res,
                           input string name);
        int cyc;
        tick();
        valid_i = 1'b1;
        op_i    = op;
        tag_i   = tag;
        ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        cyc = 1;
        while (!valid_o_r && cyc < 10) begin
            tick();
            cyc++;
        end
        check({name, "_lat"}, 32'(cyc), 32'd3);
        check({name, "_res"}, 32'(res_o_r), 32'(exp_res));
        check({name, "_tag"}, 32'(tag_o_r), 32'(tag));
    endtask

    task automatic drain(input string name);
        int c;
        c       = 0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        while ((exp_r_q.size() != 0 || exp_t_q.size() != 0 || busy_o_r) && c < 50) begin
            tick();
            c++;
        end
        check({name, "_drain_r"}, 32'(exp_r_q.size()), 32'd0);
        check({name, "_drain_t"}, 32'(exp_t_q.size()), 32'd0);
    endtask

    logic [15:0] d_op  [9] = '{16'h3F80, 16'h4000, 16'h3F00, 16'h4080, 16'hBF80,
                               16'h0000, 16'h0001, 16'h7F80, 16'h7FC1};
    logic [15:0] d_res [9] = '{16'h0000, 16'h3F31, 16'hBF31, 16'h3FB1, 16'h7FC0,
                               16'hFF80, 16'hFF80, 16'h7F80, 16'h7FC0};
    logic [15:0] snap;

    initial begin
        clear_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        op_i    = '0;
        tag_i   = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_valid_o", 32'(valid_o_r), 32'd0);
        check("rst_ready_o", 32'(ready_o_r), 32'd1);
        check("rst_busy_o",  32'(busy_o_r),  32'd0);
        check("rst_res_o",   32'(res_o_r),   32'd0);
        check("rst_tag_o",   32'(tag_o_r),   32'd0);
        check("rst_busy_t",  32'(busy_o_t),  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed values and specials
        for (int i = 0; i < 9; i++) run_one(d_op[i], 4'(i + 1), d_res[i], "directed");
        drain("directed");

        // Back-to-back stream of 8
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i < 8) begin
                valid_i = 1'b1;
                op_i    = rand_op();
                tag_i   = 4'(i);
            end else begin
                valid_i = 1'b0;
            end
            if (i >= 3 && i <= 10) check("b2b_valid", 32'(valid_o_r), 32'd1);
            if (i == 11) check("b2b_end", 32'(valid_o_r), 32'd0);
        end
        drain("b2b");

        // Output stall for 5 cycles
        for (int i = 0; i < 8; i++) begin
            tick();
            ready_i = (i >= 5);
            if (i < 3) begin
                valid_i = 1'b1;
                op_i    = rand_op();
                tag_i   = 4'(8 + i);
            end else if (i == 3) begin
                op_i  = 16'h4000;
                tag_i = 4'hB;
            end else if (i > 5) begin
                valid_i = 1'b0;
            end
            #1;
            if (i == 3 || i == 4) begin
                check("stall_ready_o", 32'(ready_o_r), 32'd0);
                check("stall_valid_o", 32'(valid_o_r), 32'd1);
                check("stall_busy_o",  32'(busy_o_r),  32'd1);
            end
            if (i == 3) snap = res_o_r;
            if (i == 4) check("stall_res_stable", 32'(res_o_r), 32'(snap));
        end
        drain("stall");

        // Synchronous flush with 3 entries in flight
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            valid_i = 1'b1;
            op_i    = rand_op();
            tag_i   = 4'(i + 4);
        end
        tick();
        op_i    = 16'h4080;
        clear_i = 1'b1;
        #1;
        check("clear_ready_o", 32'(ready_o_r), 32'd0);
        check("clear_busy_before", 32'(busy_o_r), 32'd1);
        tick();
        clear_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        check("clear_valid_o", 32'(valid_o_r), 32'd0);
        check("clear_busy_o",  32'(busy_o_r),  32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("clear_no_leak", 32'(valid_o_r), 32'd0);
        end

        // Asynchronous reset while stalled full
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            valid_i = 1'b1;
            op_i    = rand_op();
            tag_i   = 4'(i + 12);
        end
        tick();
        valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_valid_o", 32'(valid_o_r), 32'd0);
        check("arst_ready_o", 32'(ready_o_r), 32'd1);
        check("arst_busy_o",  32'(busy_o_r),  32'd0);
        check("arst_res_o",   32'(res_o_r),   32'd0);
        check("arst_tag_o",   32'(tag_o_r),   32'd0);
        check("arst_res_t",   32'(res_o_t),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_one(16'h4000, 4'h9, 16'h3F31, "post_rst");
        drain("post_rst");

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            tick();
            valid_i = ($urandom_range(0, 3) != 0);
            op_i    = rand_op();
            tag_i   = 4'($urandom_range(0, 15));
            ready_i = ($urandom_range(0, 3) != 0);
        end
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
